// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch pipe.
// Control-bundle bit taps, halt/NOP encodings, FSM states.
package fetch_pkg;

  localparam int unsigned CTRL_MEMREAD = 0;
  localparam int unsigned CTRL_FLAGWR  = 1;

  localparam logic [4:0]  HALT_OP = 5'b11111;
  localparam logic [15:0] NOP     = 16'h0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  typedef struct packed {
    logic [15:0] g1;
    logic [15:0] g2;
  } if_id_t;

  localparam if_id_t NOP_PAIR = '{g1: NOP, g2: NOP};

  function automatic logic is_halt(
    input logic [15:0] op
  );
    return op[15:11] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_pipe_ctrl_if.sv
// fetch_pipe_ctrl_if: hazard, imem and decoder bus.
// master = hazard unit/imem/decoder side, slave = fetch_pipe_ctrl.
interface fetch_pipe_ctrl_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned CTRL_W = 8
);

  logic              PCWrite;
  logic              IFWrite;
  logic              IDEX_ctrl_flush;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic [15:0]       opcodeg1;
  logic [15:0]       opcodeg2;
  logic [PC_W-1:0]   IFID_pc;
  logic [CTRL_W-1:0] ctrl_in;
  logic [2:0]        rd_in;
  logic [CTRL_W-1:0] IDEX_ctrl;
  logic              IDEX_MemRead;
  logic              IDEX_flagWrite1;
  logic [2:0]        IDEX_rd;

  modport master (
    output PCWrite, IFWrite, IDEX_ctrl_flush,
    output br_taken, br_target,
    output imem_rdata, ctrl_in, rd_in,
    input  imem_addr, opcodeg1, opcodeg2,
    input  IFID_pc, IDEX_ctrl, IDEX_rd,
    input  IDEX_MemRead, IDEX_flagWrite1
  );

  modport slave (
    input  PCWrite, IFWrite, IDEX_ctrl_flush,
    input  br_taken, br_target,
    input  imem_rdata, ctrl_in, rd_in,
    output imem_addr, opcodeg1, opcodeg2,
    output IFID_pc, IDEX_ctrl, IDEX_rd,
    output IDEX_MemRead, IDEX_flagWrite1
  );

endinterface

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter, async clear.
// Counts inc pulses and sticks at 16'hFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: PC, IF/ID pair and ID/EX ctrl registers.
// Applies hazard-unit stall/flush and EX branch redirect.
module fetch_pipe_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CTRL_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_pipe_ctrl_if.slave bus,
  output logic             halted,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      squash_cnt
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_ifid_pc;
  if_id_t            r_ifid;
  logic [CTRL_W-1:0] r_idex_ctrl;
  logic [2:0]        r_idex_rd;

  logic   w_run;
  logic   w_br;
  logic   w_adv;
  logic   w_ld;
  logic   w_h1;
  logic   w_h2;
  if_id_t w_fetch;

  assign w_run = (r_state == RUN);
  assign w_br  = w_run & bus.br_taken;
  assign w_adv = w_run & ~bus.br_taken;
  assign w_ld  = w_adv & bus.IFWrite;

  assign w_h1 = is_halt(bus.imem_rdata[31:16]);
  assign w_h2 = is_halt(bus.imem_rdata[15:0]);

  // Slot 2 after a slot-1 halt must never issue.
  always_comb begin
    w_fetch.g1 = bus.imem_rdata[31:16];
    w_fetch.g2 = w_h1 ? NOP : bus.imem_rdata[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN: begin
        if (w_ld && (w_h1 || w_h2)) begin
          w_state_nxt = HALT;
        end
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ifid      <= NOP_PAIR;
      r_ifid_pc   <= '0;
      r_idex_ctrl <= '0;
      r_idex_rd   <= '0;
    end else begin
      unique case (1'b1)
        w_br: begin
          r_pc        <= bus.br_target;
          r_ifid      <= NOP_PAIR;
          r_idex_ctrl <= '0;
          r_idex_rd   <= bus.rd_in;
        end
        w_adv: begin
          if (bus.PCWrite) begin
            r_pc <= r_pc + PC_W'(2);
          end
          if (bus.IFWrite) begin
            r_ifid    <= w_fetch;
            r_ifid_pc <= r_pc;
          end
          r_idex_ctrl <= bus.IDEX_ctrl_flush ?
                         '0 : bus.ctrl_in;
          r_idex_rd   <= bus.rd_in;
        end
        default: begin
          // BOOT and HALT: PC frozen, bubbles only.
          r_ifid      <= NOP_PAIR;
          r_idex_ctrl <= '0;
        end
      endcase
    end
  end

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_adv & ~bus.PCWrite),
    .cnt   (stall_cnt)
  );

  sat_counter16 u_squash_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_br),
    .cnt   (squash_cnt)
  );

  assign bus.imem_addr       = r_pc;
  assign bus.opcodeg1        = r_ifid.g1;
  assign bus.opcodeg2        = r_ifid.g2;
  assign bus.IFID_pc         = r_ifid_pc;
  assign bus.IDEX_ctrl       = r_idex_ctrl;
  assign bus.IDEX_rd         = r_idex_rd;
  assign bus.IDEX_MemRead    = r_idex_ctrl[CTRL_MEMREAD];
  assign bus.IDEX_flagWrite1 = r_idex_ctrl[CTRL_FLAGWR];
  assign halted              = (r_state == HALT);

endmodule
